// File: rtl/axi_ar_snoop_buffered_pkg.sv
// rtl/axi_ar_snoop_buffered_pkg.sv - shared record layout, tags and width check for the AXI snoopers
package axi_snoop_pkg;

    // Field widths of the default AR record layout
    localparam int REC_TYPE_W = 3;
    localparam int REC_ID_W   = 32;
    localparam int REC_LEN_W  = 8;
    localparam int REC_SEQ_W  = 16;
    localparam int REC_ADDR_W = 64;
    localparam int REC_DATA_W = 128;
    localparam int REC_PAD_W  = REC_DATA_W - (REC_TYPE_W + REC_ID_W + REC_LEN_W + REC_SEQ_W + REC_ADDR_W);

    localparam logic [REC_TYPE_W-1:0] STREAM_TYPE_AR = 3'b000;

    // Header fields sit in the MSBs, address in the LSBs, zero pad in between
    typedef struct packed {
        logic [REC_TYPE_W-1:0] rec_type;
        logic [REC_ID_W-1:0]   id;
        logic [REC_LEN_W-1:0]  len;
        logic [REC_SEQ_W-1:0]  seq;
        logic [REC_PAD_W-1:0]  pad;
        logic [REC_ADDR_W-1:0] addr;
    } ar_record_t;

    function automatic bit record_fits(input int data_w, input int type_w, input int id_w,
                                       input int len_w, input int seq_w, input int addr_w);
        return data_w >= (type_w + id_w + len_w + seq_w + addr_w);
    endfunction

endpackage

// File: rtl/axi_ar_snoop_buffered_if.sv
// rtl/axi_ar_snoop_buffered_if.sv - AXI4 AR channel and AXI-Stream bundles
interface axi_ar_if #(
    parameter int ID_WIDTH   = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int BURST_LEN  = 8,
    parameter int LOCK_WIDTH = 2,
    parameter int USER_WIDTH = 64
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [BURST_LEN-1:0]  arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [LOCK_WIDTH-1:0] arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arregion;
    logic [3:0]            arqos;
    logic [USER_WIDTH-1:0] aruser;
    logic                  arvalid;
    logic                  arready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, aruser, arvalid,
        input  arready
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, aruser, arvalid,
        output arready
    );
endinterface

interface axis_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axi_ar_snoop_buffered_fifo.sv
// rtl/axi_ar_snoop_buffered_fifo.sv - first-word fall-through register FIFO shared by the snoopers
module snoop_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    // Overflow and underflow requests are ignored so callers need no guards
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign full_o  = (level_q == LVL_FULL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Storage is cleared on reset so the head word reads as zero when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Occupancy is unchanged when a push and a pop coincide
    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop)      level_d = level_q + LVL_ONE;
        else if (!do_push && do_pop) level_d = level_q - LVL_ONE;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/axi_ar_snoop_buffered.sv
// rtl/axi_ar_snoop_buffered.sv - transparent AR snooper queuing one stream record per handshake
module axi_ar_snoop_buffered
    import axi_snoop_pkg::*;
#(
    parameter int DATA_WIDTH        = 128,
    parameter int ADDR_WIDTH        = 64,
    parameter int ID_WIDTH          = 32,
    parameter int BURST_LEN         = 8,
    parameter int LOCK_WIDTH        = 2,
    parameter int USER_WIDTH        = 64,
    parameter int SEQ_WIDTH         = 16,
    parameter int STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = STREAM_TYPE_AR,
    parameter int DEPTH             = 8,
    parameter bit DROP_ON_FULL      = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    axi_ar_if.slave                snoop,
    axi_ar_if.master               forward,
    axis_if.master                 m_axis,
    output logic [15:0]            drop_count,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int HDR_W = STREAM_TYPE_WIDTH + ID_WIDTH + BURST_LEN + SEQ_WIDTH;
    localparam logic [SEQ_WIDTH-1:0] SEQ_ONE = SEQ_WIDTH'(1);

    if (!record_fits(DATA_WIDTH, STREAM_TYPE_WIDTH, ID_WIDTH, BURST_LEN, SEQ_WIDTH, ADDR_WIDTH)) begin : g_bad_width
        $error("axi_ar_snoop_buffered: DATA_WIDTH too small for record");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("axi_ar_snoop_buffered: DEPTH must be a power of two and at least 2");
    end

    logic                  full, empty, gate, hs, push, drop, pop;
    logic [DATA_WIDTH-1:0] rec_data;
    logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
    logic [15:0]           drop_q, drop_d;

    // In stall mode a full queue closes the channel; reset also closes it
    assign gate = enable && !reset && (DROP_ON_FULL || !full);

    assign forward.arid     = snoop.arid;
    assign forward.araddr   = snoop.araddr;
    assign forward.arlen    = snoop.arlen;
    assign forward.arsize   = snoop.arsize;
    assign forward.arburst  = snoop.arburst;
    assign forward.arlock   = snoop.arlock;
    assign forward.arcache  = snoop.arcache;
    assign forward.arprot   = snoop.arprot;
    assign forward.arregion = snoop.arregion;
    assign forward.arqos    = snoop.arqos;
    assign forward.aruser   = snoop.aruser;
    assign forward.arvalid  = snoop.arvalid && gate;
    assign snoop.arready    = forward.arready && gate;

    assign hs   = forward.arvalid && forward.arready;
    assign push = hs && !full;
    assign drop = hs && full;
    assign pop  = m_axis.tvalid && m_axis.tready;

    assign m_axis.tvalid = !empty;
    assign m_axis.tlast  = 1'b1;
    assign drop_count    = drop_q;

    // Pack the record: header in the MSBs, address in the LSBs, zeros between
    always_comb begin
        rec_data = '0;
        rec_data[ADDR_WIDTH-1:0] = snoop.araddr;
        rec_data[DATA_WIDTH-1 -: HDR_W] = {STREAM_TYPE, snoop.arid, snoop.arlen, seq_q};
    end

    // Sequence advances on every handshake, dropped or not, so gaps are visible
    always_comb begin
        seq_d  = hs ? seq_q + SEQ_ONE : seq_q;
        drop_d = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    end

    // Sequence and saturating drop counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q  <= '0;
            drop_q <= '0;
        end else begin
            seq_q  <= seq_d;
            drop_q <= drop_d;
        end
    end

    snoop_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .din_i   (rec_data),
        .pop_i   (pop),
        .dout_o  (m_axis.tdata),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );
endmodule

// File: doc/axi_ar_snoop_buffered.md
# axi_ar_snoop_buffered

Parametrised AR-channel snooper that sits transparently between an AXI4 master and slave. It captures every completed AR handshake into a record and queues the record in an internal FIFO, so the AXI-Stream consumer can apply backpressure. Full-FIFO behaviour is selectable: stall the AR channel, or let the transaction through and count the lost record. Each record carries a wrapping sequence number, so downstream logic can detect gaps.

## Interface
- DATA_WIDTH, 128: stream record width.
- ADDR_WIDTH, 64: AR address width.
- ID_WIDTH, 32: ARID width.
- BURST_LEN, 8: ARLEN width.
- LOCK_WIDTH, 2: ARLOCK width.
- USER_WIDTH, 64: ARUSER width.
- SEQ_WIDTH, 16: sequence-number width.
- STREAM_TYPE, 3'b000: record tag.
- STREAM_TYPE_WIDTH, 3: tag width.
- DEPTH, 8: FIFO entries. Must be a power of two and at least 2.
- DROP_ON_FULL, 0: full-FIFO mode. 0 stalls the AR channel; 1 forwards the transaction and drops the record.
- Elaboration error unless DATA_WIDTH >= STREAM_TYPE_WIDTH+ID_WIDTH+BURST_LEN+SEQ_WIDTH+ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when 0, the AR channel is fully blocked.
- snoop_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arregion/arqos/aruser  in  per-field width  AR payload from the master.
- snoop_arvalid  in  1;  snoop_arready  out  1.
- forward_ar* (same eleven fields)  out  per-field width  payload to the slave, combinational copy of snoop_ar*.
- forward_arvalid  out  1;  forward_arready  in  1.
- m_axis_tdata  out  DATA_WIDTH  record.
- m_axis_tvalid  out  1;  m_axis_tready  in  1.
- m_axis_tlast  out  1  tied to 1; one beat per record.
- drop_count  out  16  saturating count of dropped records.
- fifo_level  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- gate = enable && (DROP_ON_FULL || !full).
- forward_arvalid = snoop_arvalid && gate.
- snoop_arready = forward_arready && gate.
- hs = forward_arvalid && forward_arready. Only a real handshake creates a record; a valid without ready never does.
- Record layout: {STREAM_TYPE, arid, arlen, seq, zero pad, araddr}, with araddr in the LSBs.
- seq register:
  - increments modulo 2^SEQ_WIDTH on every hs, including hs whose record is dropped.
  - the record carries the pre-increment value.
- Push condition: hs && !full.
- Drop condition: hs && full. This occurs only when DROP_ON_FULL=1. drop_count increments and holds at 16'hFFFF.
- Pop condition: m_axis_tvalid && m_axis_tready.
- Stall mode: full blocks hs even when a pop happens in the same cycle. There is no full-bypass path.
- Drop mode: a push and a pop in the same cycle while full is still a drop. Full is evaluated from the registered level.
- Push and pop in the same cycle when not full and not empty: level is unchanged.
- enable deasserting mid-stream does not affect queued records; the stream continues to drain.

## Timing
- Reset values:
  - m_axis_tvalid=0; fifo_level=0; drop_count=0; seq=0; pointers=0.
  - m_axis_tdata=0 after reset. It is otherwise don't-care while tvalid=0.
  - AR outputs are combinational and follow their inputs.
- Forward path: zero latency.
- Record latency: tvalid and tdata appear the cycle after the capturing hs. The FIFO output is registered and first-word fall-through.
- Stream handshake rules:
  - tdata is stable while tvalid=1 and tready=0.
  - tvalid never drops without a pop.
- Back-to-back pops: one record per cycle with no bubbles.
- full = (level==DEPTH); empty = (level==0). Pointers wrap at DEPTH.
- Reset asserted mid-burst:
  - the FIFO is flushed immediately and asynchronously.
  - snoop_arready and forward_arvalid are forced to 0 while reset=1.

## Structure
- Package axi_snoop_pkg:
  - packed struct ar_record_t with fields type, id, len, seq, addr.
  - STREAM_TYPE_AR constant.
  - width-check function.
- Sub-module snoop_sync_fifo (WIDTH, DEPTH): FWFT, push/pop/full/empty/level, asynchronous active-high reset. It is reused later by the AW and B snoopers.
- Top level contains the gating logic, seq counter, drop counter and record packing.

## Test plan
- Single read: araddr=0x1000, arid=5, arlen=3, both readies high -> forward passthrough in the same cycle; one record next cycle with seq=0 and tlast=1.
- Stall mode, DEPTH=8, tready=0, nine ARs -> eight handshakes complete, snoop_arready=0 on the ninth, fifo_level=8; one pop -> the ninth completes.
- Drop mode, same stimulus -> nine forwarded, drop_count=1; drained records carry seq 0..7; the next record carries seq=9.
- forward_arready=0 for 5 cycles with arvalid=1 -> no record and seq unchanged; ready rises -> exactly one record.
- enable=0 with arvalid=1 -> forward_arvalid=0 and snoop_arready=0; queued records still drain.
- Reset pulse with 4 queued records and tvalid=1 -> tvalid=0, level=0, seq=0 immediately; the next record after release has seq=0.
